ts_sync_aligner: RTL and testbench
==================================

Name: ts_sync_aligner

Overview:
Per-stream MPEG-2 TS packet aligner, placed directly upstream of each packet_loss_counter lane. Takes a raw byte stream with a per-byte valid and searches for the 0x47 sync byte at PKT_LEN spacing. After LOCK_COUNT consistent sync bytes it declares lock and forwards bytes with valid/sync framing for the continuity-counter stage. It drops lock after UNLOCK_COUNT consecutive missed sync bytes and counts sync losses.

Parameters:
PKT_LEN, 188, packet length in bytes (byte-position counter width = clog2(PKT_LEN))
SYNC_BYTE, 8'h47, sync byte value
LOCK_COUNT, 3, consecutive correctly spaced sync bytes required to lock (>=1)
UNLOCK_COUNT, 3, consecutive missed sync bytes that drop lock (>=1)

Ports:
clk  in  1  single system clock; all logic rising-edge
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  data_in carries a byte this cycle
data_in  in  8  raw TS byte
clr_count  in  1  synchronous clear of sync_loss_count
data_out  out  8  forwarded byte
valid_out  out  1  data_out valid (locked packets only)
sync_out  out  1  high with valid_out on byte 0 of each packet
locked  out  1  high while in LOCKED
sync_loss_count  out  16  saturating count of LOCKED->HUNT transitions

Behaviour:
- Reset (async, reset_n=0): state=HUNT; pos, hit_cnt, miss_cnt=0; data_out=0, valid_out=0, sync_out=0, locked=0, sync_loss_count=0. Reset mid-packet discards all alignment.
- Internal state advances only on cycles with valid_in=1. Gaps of any length are transparent.
- pos = position within the current packet, 0..PKT_LEN-1. It increments on each valid byte and wraps from PKT_LEN-1 to 0. "Check byte" = the valid byte arriving when pos==0.
- HUNT: locked=0, no output. A valid byte == SYNC_BYTE triggers: if LOCK_COUNT==1, go directly to LOCKED (this byte is output as sync); otherwise go to VERIFY with hit_cnt=1, pos=1. Any other byte keeps HUNT.
- VERIFY: no output. Non-check bytes only advance pos; payload 0x47s are ignored. At the check byte:
  - == SYNC_BYTE: hit_cnt++. If the new hit_cnt == LOCK_COUNT, go to LOCKED with miss_cnt=0; this byte is forwarded with sync_out=1.
  - != SYNC_BYTE: go to HUNT. That byte is not re-evaluated.
- LOCKED: locked=1. Every valid byte is forwarded. At the check byte:
  - == SYNC_BYTE: miss_cnt=0; forwarded with sync_out=1.
  - != SYNC_BYTE: miss_cnt++.
    - If miss_cnt reaches UNLOCK_COUNT: go to HUNT, byte not forwarded, locked falls with that output cycle, sync_loss_count++ (saturates at 16'hFFFF).
    - Otherwise (flywheel): byte forwarded with sync_out=1, so downstream framing is preserved.
- Outputs are registered, 1 cycle of latency. data_out, valid_out and sync_out reflect the byte sampled on the previous edge. sync_out is never high without valid_out. data_out holds its value when valid_out=0.
- locked is registered with the outputs: its rising edge coincides with the first valid_out/sync_out.
- clr_count: sync_loss_count=0 on the next edge. If a loss event occurs in the same cycle, the clear wins and the result is 0.
- Width rules: hit_cnt and miss_cnt are sized to hold LOCK_COUNT and UNLOCK_COUNT respectively. pos never exceeds PKT_LEN-1.

Test Plan:
- Clean stream, 0x47 at byte 0 then every 188 bytes, valid_in=1 continuously -> first valid_out/sync_out/locked is 1 cycle after input byte 376 (third sync); every 188th output thereafter has sync_out=1; sync_loss_count=0.
- 50 bytes of 0x00 then a clean stream, with a 0x47 planted at payload offset 10 of the first packet -> false candidate rejected or ignored, lock at the third true sync, no output before it.
- Locked; corrupt one sync byte to 0x46 -> byte still forwarded with sync_out=1, locked stays 1, miss counter resets on the next good sync.
- Locked; corrupt three consecutive sync bytes -> first two forwarded with sync_out=1, third not forwarded; locked=0 from that cycle, sync_loss_count=1; relock after three further good syncs.
- Clean stream with random valid_in gaps (~30% idle) -> identical output byte sequence and sync positions as the gap-free run; valid_out pattern tracks valid_in delayed by 1 cycle.
- Assert reset_n mid-packet while locked, then release -> all outputs 0 immediately (async); re-lock requires three fresh syncs. Separately, clr_count pulsed together with a loss event -> sync_loss_count=0.

Source files
------------

// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner: MPEG-2 TS packet aligner.
// Hunts for SYNC_BYTE at PKT_LEN spacing. It locks after LOCK_COUNT good syncs and
// forwards framed bytes (valid/sync) while locked. A flywheel tolerates up to
// UNLOCK_COUNT-1 missed syncs. Each loss of lock is counted, saturating.
module ts_sync_aligner #(
  parameter int          PKT_LEN      = 188,
  parameter logic [7:0]  SYNC_BYTE    = 8'h47,
  parameter int          LOCK_COUNT   = 3,
  parameter int          UNLOCK_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  input  logic        clr_count,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sync_out,
  output logic        locked,
  output logic [15:0] sync_loss_count
);

  localparam int POS_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(PKT_LEN - 1);
  // Position of the byte that follows a sync byte (wraps immediately for 1-byte packets)
  localparam logic [POS_W-1:0]  POS_ONE  = (PKT_LEN > 1) ? POS_W'(1) : POS_W'(0);
  localparam logic [HIT_W-1:0]  LOCK_L   = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] UNLOCK_L = MISS_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state_reg;
  logic [POS_W-1:0]    pos_reg;
  logic [HIT_W-1:0]    hit_cnt_reg;
  logic [MISS_W-1:0]   miss_cnt_reg;

  logic                is_sync;
  logic                is_check;
  logic [POS_W-1:0]    pos_next;
  logic [HIT_W-1:0]    hit_inc;
  logic [MISS_W-1:0]   miss_inc;
  logic                loss_event;

  // Decode the incoming byte against the current alignment
  always_comb begin
    is_sync    = (data_in == SYNC_BYTE);
    is_check   = (pos_reg == '0);
    pos_next   = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
    hit_inc    = hit_cnt_reg + HIT_W'(1);
    miss_inc   = miss_cnt_reg + MISS_W'(1);
    loss_event = valid_in && (state_reg == LOCKED) && is_check && !is_sync &&
                 (miss_inc == UNLOCK_L);
  end

  // Alignment FSM with registered framing outputs and loss counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= HUNT;
      pos_reg         <= '0;
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
      data_out        <= 8'h00;
      valid_out       <= 1'b0;
      sync_out        <= 1'b0;
      locked          <= 1'b0;
      sync_loss_count <= 16'h0000;
    end else begin
      valid_out <= 1'b0;
      sync_out  <= 1'b0;

      // Clear takes priority over a coincident loss event
      if (clr_count)
        sync_loss_count <= 16'h0000;
      else if (loss_event && (sync_loss_count != 16'hFFFF))
        sync_loss_count <= sync_loss_count + 16'd1;

      if (valid_in) begin
        case (state_reg)
          HUNT: begin
            if (is_sync) begin
              pos_reg <= POS_ONE;
              if (LOCK_COUNT == 1) begin
                state_reg    <= LOCKED;
                miss_cnt_reg <= '0;
                data_out     <= data_in;
                valid_out    <= 1'b1;
                sync_out     <= 1'b1;
                locked       <= 1'b1;
              end else begin
                state_reg   <= VERIFY;
                hit_cnt_reg <= HIT_W'(1);
              end
            end
          end

          VERIFY: begin
            if (is_check && !is_sync) begin
              // Candidate failed; the failing byte is not re-examined as a new sync
              state_reg   <= HUNT;
              pos_reg     <= '0;
              hit_cnt_reg <= '0;
            end else begin
              pos_reg <= pos_next;
              if (is_check) begin
                hit_cnt_reg <= hit_inc;
                if (hit_inc == LOCK_L) begin
                  state_reg    <= LOCKED;
                  miss_cnt_reg <= '0;
                  data_out     <= data_in;
                  valid_out    <= 1'b1;
                  sync_out     <= 1'b1;
                  locked       <= 1'b1;
                end
              end
            end
          end

          LOCKED: begin
            if (loss_event) begin
              state_reg    <= HUNT;
              pos_reg      <= '0;
              hit_cnt_reg  <= '0;
              miss_cnt_reg <= '0;
              locked       <= 1'b0;
            end else begin
              // Missed syncs below the threshold still frame as sync (flywheel)
              pos_reg   <= pos_next;
              data_out  <= data_in;
              valid_out <= 1'b1;
              sync_out  <= is_check;
              if (is_check)
                miss_cnt_reg <= is_sync ? '0 : miss_inc;
            end
          end

          default: begin
            state_reg <= HUNT;
            pos_reg   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed testbench for ts_sync_aligner (PKT_LEN=188, LOCK/UNLOCK=3).
module tb_ts_sync_aligner;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        clr_count;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        sync_out;
  logic        locked;
  logic [15:0] sync_loss_count;

  int checks;
  int errors;

  // Per-packet observations filled by send_packet
  int          nv;     // forwarded bytes
  int          ns;     // bytes with sync_out
  int          derr;   // forwarded bytes whose data differed from input
  int          gerr;   // idle cycles with valid_out or data_out change
  int          serr;   // sync_out without valid_out
  logic        sf;     // sync_out on packet byte 0
  logic        lf;     // locked after packet byte 0
  logic [7:0]  df;     // data_out after packet byte 0

  ts_sync_aligner dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .clr_count       (clr_count),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .sync_out        (sync_out),
    .locked          (locked),
    .sync_loss_count (sync_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pay(input int off);
    logic [7:0] b;
    b = 8'(off) ^ 8'hA5;
    if (b == 8'h47) b = 8'h48;
    return b;
  endfunction

  // One valid byte; outputs for it are sampled 1 ns after the capturing edge
  task automatic send_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    valid_in  = 1'b1;
    data_in   = b;
    clr_count = clr;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    if (valid_out === 1'b1) begin
      nv++;
      if (data_out !== b) derr++;
    end
    if (sync_out === 1'b1) ns++;
    if (sync_out === 1'b1 && valid_out !== 1'b1) serr++;
  endtask

  task automatic send_idle();
    logic [7:0] prev;
    prev = data_out;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h47;
    @(posedge clk);
    #1;
    if (valid_out !== 1'b0 || data_out !== prev) gerr++;
  endtask

  // Send one 188-byte packet with chosen sync value, optional planted 0x47,
  // optional idle gaps (percent) and optional clr_count on byte 0.
  task automatic send_packet(input logic [7:0] sv, input int plant, input int gap_pct,
                             input logic clr0);
    nv = 0; ns = 0; derr = 0; serr = 0;
    for (int i = 0; i < 188; i++) begin
      if (gap_pct > 0)
        while ($urandom_range(99) < gap_pct) send_idle();
      if (i == 0) begin
        send_byte(sv, clr0);
        sf = sync_out;
        lf = locked;
        df = data_out;
      end else begin
        send_byte((i == plant) ? 8'h47 : pay(i), 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    data_in   = 8'h00;
    clr_count = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic lock_up();
    do_reset();
    repeat (3) send_packet(8'h47, -1, 0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({data_out, valid_out, sync_out, locked, sync_loss_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got d=%0h v=%0b s=%0b l=%0b cnt=%0d, expected all 0",
               data_out, valid_out, sync_out, locked, sync_loss_count);
    end
  endtask

  task automatic test_clean_lock();
    int early;
    do_reset();
    send_packet(8'h47, -1, 0, 1'b0);
    early = nv;
    send_packet(8'h47, -1, 0, 1'b0);
    early += nv;
    checks++;
    if (early !== 0) begin errors++; $display("FAIL clean_no_early: %0d outputs, expected 0", early); end
    send_packet(8'h47, -1, 0, 1'b0);
    checks++;
    if (sf !== 1'b1 || lf !== 1'b1 || df !== 8'h47) begin
      errors++; $display("FAIL clean_lock_byte376: sync=%0b locked=%0b data=%0h, expected 1 1 47", sf, lf, df);
    end
    checks++;
    if (nv !== 188 || ns !== 1 || derr !== 0 || serr !== 0) begin
      errors++; $display("FAIL clean_pkt3: nv=%0d ns=%0d derr=%0d serr=%0d, expected 188 1 0 0", nv, ns, derr, serr);
    end
    send_packet(8'h47, -1, 0, 1'b0);
    checks++;
    if (nv !== 188 || ns !== 1 || sf !== 1'b1 || derr !== 0) begin
      errors++; $display("FAIL clean_pkt4: nv=%0d ns=%0d sf=%0b derr=%0d, expected 188 1 1 0", nv, ns, sf, derr);
    end
    checks++;
    if (sync_loss_count !== 16'd0) begin
      errors++; $display("FAIL clean_loss_count: got %0d, expected 0", sync_loss_count);
    end
  endtask

  task automatic test_false_candidate();
    int early;
    do_reset();
    nv = 0;
    for (int i = 0; i < 50; i++) send_byte(8'h00, 1'b0);
    early = nv;
    send_packet(8'h47, 10, 0, 1'b0);
    early += nv;
    send_packet(8'h47, -1, 0, 1'b0);
    early += nv;
    checks++;
    if (early !== 0) begin errors++; $display("FAIL false_no_early: %0d outputs, expected 0", early); end
    send_packet(8'h47, -1, 0, 1'b0);
    checks++;
    if (sf !== 1'b1 || lf !== 1'b1 || nv !== 188 || ns !== 1) begin
      errors++; $display("FAIL false_lock_third: sf=%0b lf=%0b nv=%0d ns=%0d, expected 1 1 188 1", sf, lf, nv, ns);
    end
  endtask

  task automatic test_single_miss();
    lock_up();
    send_packet(8'h46, -1, 0, 1'b0);
    checks++;
    if (sf !== 1'b1 || lf !== 1'b1 || df !== 8'h46 || nv !== 188) begin
      errors++; $display("FAIL miss_flywheel: sf=%0b lf=%0b d=%0h nv=%0d, expected 1 1 46 188", sf, lf, df, nv);
    end
    send_packet(8'h47, -1, 0, 1'b0);
    send_packet(8'h46, -1, 0, 1'b0);
    send_packet(8'h46, -1, 0, 1'b0);
    checks++;
    if (sf !== 1'b1 || lf !== 1'b1 || nv !== 188 || sync_loss_count !== 16'd0) begin
      errors++; $display("FAIL miss_counter_reset: sf=%0b lf=%0b nv=%0d cnt=%0d, expected 1 1 188 0",
                         sf, lf, nv, sync_loss_count);
    end
  endtask

  task automatic test_loss_relock();
    int early;
    lock_up();
    send_packet(8'h46, -1, 0, 1'b0);
    send_packet(8'h46, -1, 0, 1'b0);
    checks++;
    if (sf !== 1'b1 || lf !== 1'b1) begin
      errors++; $display("FAIL loss_second_miss: sf=%0b lf=%0b, expected 1 1", sf, lf);
    end
    send_packet(8'h46, -1, 0, 1'b0);
    checks++;
    if (lf !== 1'b0 || nv !== 0 || sync_loss_count !== 16'd1) begin
      errors++; $display("FAIL loss_third_miss: lf=%0b nv=%0d cnt=%0d, expected 0 0 1", lf, nv, sync_loss_count);
    end
    send_packet(8'h47, -1, 0, 1'b0);
    early = nv;
    send_packet(8'h47, -1, 0, 1'b0);
    early += nv;
    send_packet(8'h47, -1, 0, 1'b0);
    checks++;
    if (early !== 0 || sf !== 1'b1 || lf !== 1'b1 || nv !== 188 || sync_loss_count !== 16'd1) begin
      errors++; $display("FAIL loss_relock: early=%0d sf=%0b lf=%0b nv=%0d cnt=%0d, expected 0 1 1 188 1",
                         early, sf, lf, nv, sync_loss_count);
    end
  endtask

  task automatic test_gaps();
    int early;
    do_reset();
    gerr = 0;
    send_packet(8'h47, -1, 30, 1'b0);
    early = nv;
    send_packet(8'h47, -1, 30, 1'b0);
    early += nv;
    send_packet(8'h47, -1, 30, 1'b0);
    checks++;
    if (early !== 0 || sf !== 1'b1 || nv !== 188 || ns !== 1 || derr !== 0) begin
      errors++; $display("FAIL gaps_lock: early=%0d sf=%0b nv=%0d ns=%0d derr=%0d, expected 0 1 188 1 0",
                         early, sf, nv, ns, derr);
    end
    send_packet(8'h47, -1, 30, 1'b0);
    checks++;
    if (sf !== 1'b1 || nv !== 188 || ns !== 1 || derr !== 0 || serr !== 0) begin
      errors++; $display("FAIL gaps_pkt4: sf=%0b nv=%0d ns=%0d derr=%0d serr=%0d, expected 1 188 1 0 0",
                         sf, nv, ns, derr, serr);
    end
    checks++;
    if (gerr !== 0) begin errors++; $display("FAIL gaps_idle_cycles: %0d bad idle cycles, expected 0", gerr); end
  endtask

  task automatic test_async_reset();
    int early;
    lock_up();
    for (int i = 0; i < 94; i++) send_byte((i == 0) ? 8'h47 : pay(i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || sync_out !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL async_reset: d=%0h v=%0b s=%0b l=%0b, expected 0 0 0 0",
                         data_out, valid_out, sync_out, locked);
    end
    @(negedge clk);
    reset_n = 1'b1;
    nv = 0;
    for (int i = 94; i < 188; i++) send_byte(pay(i), 1'b0);
    early = nv;
    send_packet(8'h47, -1, 0, 1'b0);
    early += nv;
    send_packet(8'h47, -1, 0, 1'b0);
    early += nv;
    send_packet(8'h47, -1, 0, 1'b0);
    checks++;
    if (early !== 0 || sf !== 1'b1 || lf !== 1'b1) begin
      errors++; $display("FAIL async_relock: early=%0d sf=%0b lf=%0b, expected 0 1 1", early, sf, lf);
    end
  endtask

  task automatic test_clr_with_loss();
    lock_up();
    repeat (3) send_packet(8'h46, -1, 0, 1'b0);
    repeat (3) send_packet(8'h47, -1, 0, 1'b0);
    checks++;
    if (sync_loss_count !== 16'd1 || lf !== 1'b1) begin
      errors++; $display("FAIL clr_pre: cnt=%0d lf=%0b, expected 1 1", sync_loss_count, lf);
    end
    repeat (2) send_packet(8'h46, -1, 0, 1'b0);
    send_packet(8'h46, -1, 0, 1'b1);
    checks++;
    if (sync_loss_count !== 16'd0 || lf !== 1'b0) begin
      errors++; $display("FAIL clr_wins: cnt=%0d lf=%0b, expected 0 0", sync_loss_count, lf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    gerr   = 0;
    test_reset();
    test_clean_lock();
    test_false_candidate();
    test_single_miss();
    test_loss_relock();
    test_gaps();
    test_async_reset();
    test_clr_with_loss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
